// File: rtl/cam_capture_fsm.sv
// Camera byte stream -> RGB111 frame-buffer writes; regwrite 1 clk after the 2nd pixel byte is sampled.
// No backpressure: the buffer always accepts, and pixels past the end of the buffer are dropped.
module cam_capture_fsm #(
    parameter int AW    = 15,
    parameter int DW    = 3,
    parameter int H_PIX = 160,
    parameter int V_PIX = 120
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init_done,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done
);

    localparam int          NPIX   = H_PIX * V_PIX;
    localparam logic [AW:0] NPIX_C = (AW+1)'(NPIX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        vs_r, vs_rr, hr_r;
    logic [2:0]  px_r;          // only R msb, G msb (byte1) and B msb (byte2) survive
    logic [1:0]  byte1_r;
    logic        phase_r;
    logic [AW:0] cnt_r;         // one bit wider so the full-frame count is representable
    logic        vs_fall, vs_rise;

    assign vs_fall = vs_rr & ~vs_r;
    assign vs_rise = ~vs_rr & vs_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!init_done) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = WAIT_VS;
                WAIT_VS: if (vs_fall) state_nxt = CAPTURE;
                CAPTURE: state_nxt = CAPTURE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_r       <= 1'b0;
            vs_rr      <= 1'b0;
            hr_r       <= 1'b0;
            px_r       <= '0;
            byte1_r    <= '0;
            phase_r    <= 1'b0;
            cnt_r      <= '0;
            addr_in    <= '0;
            data_in    <= '0;
            regwrite   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vs_r       <= vsync;
            vs_rr      <= vs_r;
            hr_r       <= href;
            px_r       <= {px_data[7], px_data[4], px_data[2]};
            regwrite   <= 1'b0;
            frame_done <= 1'b0;
            if (!init_done) begin
                phase_r <= 1'b0;
                cnt_r   <= '0;
                addr_in <= '0;
                data_in <= '0;
            end else begin
                case (state)
                    WAIT_VS: begin
                        phase_r <= 1'b0;
                        if (vs_fall) cnt_r <= '0;
                    end
                    CAPTURE: begin
                        if (vs_rise) begin
                            frame_done <= 1'b1;
                            cnt_r      <= '0;
                            addr_in    <= '0;
                            phase_r    <= 1'b0;
                        end else if (hr_r && !vs_r) begin
                            if (!phase_r) begin
                                byte1_r <= {px_r[2], px_r[0]};
                                phase_r <= 1'b1;
                            end else begin
                                phase_r <= 1'b0;
                                if (cnt_r < NPIX_C) begin
                                    addr_in  <= cnt_r[AW-1:0];
                                    data_in  <= DW'({byte1_r, px_r[1]});
                                    regwrite <= 1'b1;
                                    cnt_r    <= cnt_r + 1'b1;
                                end
                            end
                        end else begin
                            // href low ends the line; an unpaired first byte is discarded
                            phase_r <= 1'b0;
                        end
                    end
                    default: phase_r <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_fsm.sv
// Directed bench for cam_capture_fsm: pixel decode table plus multi-cycle frame/reset sequences.
module tb_cam_capture_fsm;

    logic        clk = 1'b0;
    logic        reset, init_done, vsync, href;
    logic [7:0]  px_data;
    logic [14:0] addr_in;
    logic [2:0]  data_in;
    logic        regwrite, frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] wa[$];
    logic [2:0]  wd[$];
    int          fd_cnt  = 0;
    int          fd_long = 0;
    logic        fd_prev = 1'b0;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl[8];

    cam_capture_fsm #(.AW(15), .DW(3), .H_PIX(160), .V_PIX(120)) dut (
        .clk        (clk),
        .reset      (reset),
        .init_done  (init_done),
        .vsync      (vsync),
        .href       (href),
        .px_data    (px_data),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (regwrite) begin
            wa.push_back(addr_in);
            wd.push_back(data_in);
        end
        if (frame_done) begin
            fd_cnt++;
            if (fd_prev) fd_long++;
        end
        fd_prev = frame_done;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixels(input logic [7:0] b0, input logic [7:0] b1, input int npix);
        for (int i = 0; i < npix; i++) begin
            href = 1'b1; px_data = b0; tick();
            px_data = b1; tick();
        end
    endtask

    task automatic end_line();
        href = 1'b0; px_data = 8'h00;
        repeat (10) tick();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1; repeat (4) tick();
        vsync = 1'b0; repeat (4) tick();
    endtask

    // Count writes in [first, first+n) whose address is not sequential from base or data differs.
    function automatic int bad_writes(input int first, input int n, input int base, input logic [2:0] d);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (int'(wa[first+i]) != base + i || wd[first+i] != d) bad++;
        end
        return bad;
    endfunction

    initial begin
        int lat;
        int n_before;

        tbl[0] = '{8'h07, 8'hFF, 3'b011};
        tbl[1] = '{8'h04, 8'h10, 3'b011};
        tbl[2] = '{8'hF8, 8'h00, 3'b100};
        tbl[3] = '{8'h80, 8'h00, 3'b100};
        tbl[4] = '{8'h04, 8'h00, 3'b010};
        tbl[5] = '{8'h00, 8'h10, 3'b001};
        tbl[6] = '{8'hFF, 8'hFF, 3'b111};
        tbl[7] = '{8'h7B, 8'hEF, 3'b000};

        reset = 1'b0; init_done = 1'b0; vsync = 1'b0; href = 1'b0; px_data = 8'h00;
        repeat (3) tick();
        check("reset_addr", int'(addr_in), 0);
        check("reset_data", int'(data_in), 0);
        check("reset_regwrite", int'(regwrite), 0);
        check("reset_frame_done", int'(frame_done), 0);

        reset = 1'b1; tick();
        init_done = 1'b1; repeat (2) tick();
        vsync_pulse();
        check("no_fd_in_wait_vs", fd_cnt, 0);

        // Frame A: full line, odd-length table line, latency probe, short frame end
        send_pixels(8'hF8, 8'h00, 160); end_line();
        check("line0_writes", wa.size(), 160);
        if (wa.size() >= 160) check("line0_seq", bad_writes(0, 160, 0, 3'b100), 0);

        for (int i = 0; i < 8; i++) send_pixels(tbl[i].b0, tbl[i].b1, 1);
        send_pixels(8'hF8, 8'h00, 152);
        href = 1'b1; px_data = 8'h07; tick();
        end_line();
        check("line1_writes", wa.size(), 320);
        for (int i = 0; i < 8; i++) begin
            if (wa.size() > 160 + i) begin
                check($sformatf("tbl%0d_data", i), int'(wd[160+i]), int'(tbl[i].exp));
                check($sformatf("tbl%0d_addr", i), int'(wa[160+i]), 160 + i);
            end
        end

        href = 1'b1; px_data = 8'h07; tick();
        px_data = 8'hFF; lat = 0;
        while (lat < 6) begin
            tick();
            href = 1'b0; px_data = 8'h00;
            lat++;
            if (regwrite) break;
        end
        check("latency_2nd_byte", lat, 2);
        end_line();
        check("line2_writes", wa.size(), 321);
        if (wa.size() == 321) begin
            check("line2_pair_addr", int'(wa[320]), 320);
            check("line2_pair_data", int'(wd[320]), 3'b011);
        end

        vsync_pulse();
        check("frameA_fd_count", fd_cnt, 1);
        check("frameA_fd_width", fd_long, 0);

        // Frame B: 125 lines, buffer holds 120
        wa.delete(); wd.delete(); fd_cnt = 0;
        for (int l = 0; l < 125; l++) begin
            send_pixels(8'h00, 8'h10, 160); end_line();
        end
        check("frameB_writes", wa.size(), 19200);
        if (wa.size() > 0) begin
            check("frameB_first_addr", int'(wa[0]), 0);
            check("frameB_last_addr", int'(wa[wa.size()-1]), 19199);
        end
        if (wa.size() >= 19200) check("frameB_seq", bad_writes(0, 19200, 0, 3'b001), 0);
        check("frameB_addr_hold", int'(addr_in), 19199);
        vsync_pulse();
        check("frameB_fd_count", fd_cnt, 1);
        check("frameB_fd_width", fd_long, 0);

        // Frame C: reset mid-line
        wa.delete(); wd.delete(); fd_cnt = 0;
        send_pixels(8'hFF, 8'hFF, 10);
        n_before = wa.size();
        reset = 1'b0; #2;
        check("midreset_addr", int'(addr_in), 0);
        check("midreset_data", int'(data_in), 0);
        check("midreset_regwrite", int'(regwrite), 0);
        check("midreset_frame_done", int'(frame_done), 0);
        tick();
        reset = 1'b1;
        send_pixels(8'hFF, 8'hFF, 10); end_line();
        check("post_reset_no_writes", wa.size(), n_before);
        vsync_pulse();
        check("post_reset_no_fd", fd_cnt, 0);

        // Frame D: init_done drop clears outputs and returns to IDLE
        wa.delete(); wd.delete();
        send_pixels(8'h07, 8'hFF, 4); end_line();
        check("frameD_writes", wa.size(), 4);
        if (wa.size() == 4) check("frameD_last_addr", int'(wa[3]), 3);
        init_done = 1'b0; tick();
        check("init_drop_addr", int'(addr_in), 0);
        check("init_drop_data", int'(data_in), 0);
        tick();
        init_done = 1'b1; tick();
        vsync_pulse();
        check("init_drop_no_fd", fd_cnt, 0);
        wa.delete(); wd.delete();
        send_pixels(8'hF8, 8'h00, 1); end_line();
        check("restart_writes", wa.size(), 1);
        if (wa.size() == 1) begin
            check("restart_addr", int'(wa[0]), 0);
            check("restart_data", int'(wd[0]), 3'b100);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
